// File: rtl/resource_branch_mo.sv
// External-resource branch with multiple requests in flight: one issue register, an in-order
// tracker of issued requests, and a result FIFO for read data headed to commit.
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 8
`endif

module resource_branch_mo #(
    parameter int unsigned data_width      = 16,
    parameter int unsigned handle_width    = 8,
    parameter int unsigned n_blocks        = 256,
    parameter int unsigned max_outstanding = 4,
    parameter bit          sign_extend     = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               write,
    input  logic [$clog2(n_blocks)-1:0]        block_in,
    input  logic [handle_width-1:0]            handle_in,
    input  logic [data_width-1:0]              arg_a_in,
    input  logic [data_width-1:0]              arg_b_in,
    input  logic [3:0]                         dest_in,
    input  logic [`COMMIT_ID_WIDTH-1:0]        commit_id_in,
    output logic                               read_req,
    output logic                               write_req,
    input  logic                               req_ready,
    output logic [handle_width-1:0]            handle_out,
    output logic signed [data_width-1:0]       arg_a_out,
    output logic signed [data_width-1:0]       arg_b_out,
    input  logic                               read_valid,
    input  logic signed [data_width-1:0]       data_in,
    input  logic                               write_ack,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [2*data_width-1:0]     result_out,
    output logic [$clog2(n_blocks)-1:0]        block_out,
    output logic [3:0]                         dest_out,
    output logic [`COMMIT_ID_WIDTH-1:0]        commit_id_out,
    output logic                               idle,
    output logic                               proto_err
);

    localparam int unsigned bw = $clog2(n_blocks);
    localparam int unsigned aw = $clog2(max_outstanding);
    localparam int unsigned cw = `COMMIT_ID_WIDTH;
    localparam int unsigned rw = 2 * data_width;
    localparam logic [aw:0]   cnt_one  = (aw+1)'(1);
    localparam logic [aw:0]   max_cred = (aw+1)'(max_outstanding);
    localparam logic [aw-1:0] ptr_one  = aw'(1);

    // Issue register
    logic                    iss_full_q, iss_write_q;
    logic [handle_width-1:0] iss_handle_q;
    logic [data_width-1:0]   iss_a_q, iss_b_q;
    logic [bw-1:0]           iss_block_q;
    logic [3:0]              iss_dest_q;
    logic [cw-1:0]           iss_cid_q;

    // Tracker FIFO
    logic                    trk_write_q [max_outstanding];
    logic [bw-1:0]           trk_block_q [max_outstanding];
    logic [3:0]              trk_dest_q  [max_outstanding];
    logic [cw-1:0]           trk_cid_q   [max_outstanding];
    logic [aw-1:0]           trk_wr_q, trk_rd_q;
    logic [aw:0]             trk_cnt_q, trk_cnt_d;

    // Result FIFO
    logic [rw-1:0]           res_data_q  [max_outstanding];
    logic [bw-1:0]           res_block_q [max_outstanding];
    logic [3:0]              res_dest_q  [max_outstanding];
    logic [cw-1:0]           res_cid_q   [max_outstanding];
    logic [aw-1:0]           res_wr_q, res_rd_q;
    logic [aw:0]             res_cnt_q, res_cnt_d;

    logic [aw:0]             credits_q, credits_d;
    logic                    proto_err_q;

    logic can_issue, issue_fire, accept;
    logic trk_empty, res_empty, resp, trk_pop, head_write, res_push, res_pop, resp_err;
    logic [rw-1:0] ext_data;

    assign can_issue  = enable && iss_full_q && (credits_q < max_cred);
    assign read_req   = can_issue && !iss_write_q;
    assign write_req  = can_issue && iss_write_q;
    assign issue_fire = can_issue && req_ready;
    assign in_ready   = enable && (!iss_full_q || issue_fire);
    assign accept     = in_valid && in_ready;

    assign handle_out = iss_handle_q;
    assign arg_a_out  = iss_a_q;
    assign arg_b_out  = iss_b_q;

    assign trk_empty  = (trk_cnt_q == '0);
    assign res_empty  = (res_cnt_q == '0);
    assign resp       = enable && (read_valid || write_ack);
    assign trk_pop    = resp && !trk_empty;
    assign head_write = trk_write_q[trk_rd_q];
    assign res_push   = trk_pop && read_valid && !head_write;
    // Any response that does not match the head, or arrives with nothing outstanding, is flagged.
    assign resp_err   = resp && (trk_empty || (read_valid && write_ack) ||
                                 (read_valid && head_write) || (write_ack && !head_write));

    assign out_valid  = enable && !res_empty;
    assign res_pop    = out_valid && out_ready;

    assign ext_data = sign_extend ? {{data_width{data_in[data_width-1]}}, data_in}
                                  : {{data_width{1'b0}}, data_in};

    assign result_out    = res_empty ? '0 : res_data_q[res_rd_q];
    assign block_out     = res_empty ? '0 : res_block_q[res_rd_q];
    assign dest_out      = res_empty ? '0 : res_dest_q[res_rd_q];
    assign commit_id_out = res_empty ? '0 : res_cid_q[res_rd_q];

    assign idle      = !iss_full_q && trk_empty && res_empty;
    assign proto_err = proto_err_q;

    // A credit comes back when a tracker entry leaves without producing a result, or on result pop.
    always_comb begin
        credits_d = credits_q;
        if (issue_fire)           credits_d = credits_d + cnt_one;
        if (trk_pop && !res_push) credits_d = credits_d - cnt_one;
        if (res_pop)              credits_d = credits_d - cnt_one;
        trk_cnt_d = trk_cnt_q;
        if (issue_fire)           trk_cnt_d = trk_cnt_d + cnt_one;
        if (trk_pop)              trk_cnt_d = trk_cnt_d - cnt_one;
        res_cnt_d = res_cnt_q;
        if (res_push)             res_cnt_d = res_cnt_d + cnt_one;
        if (res_pop)              res_cnt_d = res_cnt_d - cnt_one;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_full_q   <= 1'b0;
            iss_write_q  <= 1'b0;
            iss_handle_q <= '0;
            iss_a_q      <= '0;
            iss_b_q      <= '0;
            iss_block_q  <= '0;
            iss_dest_q   <= '0;
            iss_cid_q    <= '0;
            trk_wr_q     <= '0;
            trk_rd_q     <= '0;
            trk_cnt_q    <= '0;
            res_wr_q     <= '0;
            res_rd_q     <= '0;
            res_cnt_q    <= '0;
            credits_q    <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                iss_full_q   <= 1'b1;
                iss_write_q  <= write;
                iss_handle_q <= handle_in;
                iss_a_q      <= arg_a_in;
                iss_b_q      <= arg_b_in;
                iss_block_q  <= block_in;
                iss_dest_q   <= dest_in;
                iss_cid_q    <= commit_id_in;
            end else if (issue_fire) begin
                iss_full_q   <= 1'b0;
            end
            if (issue_fire) trk_wr_q <= trk_wr_q + ptr_one;
            if (trk_pop)    trk_rd_q <= trk_rd_q + ptr_one;
            if (res_push)   res_wr_q <= res_wr_q + ptr_one;
            if (res_pop)    res_rd_q <= res_rd_q + ptr_one;
            trk_cnt_q <= trk_cnt_d;
            res_cnt_q <= res_cnt_d;
            credits_q <= credits_d;
            if (resp_err) proto_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_fire) begin
            trk_write_q[trk_wr_q] <= iss_write_q;
            trk_block_q[trk_wr_q] <= iss_block_q;
            trk_dest_q[trk_wr_q]  <= iss_dest_q;
            trk_cid_q[trk_wr_q]   <= iss_cid_q;
        end
        if (res_push) begin
            res_data_q[res_wr_q]  <= ext_data;
            res_block_q[res_wr_q] <= trk_block_q[trk_rd_q];
            res_dest_q[res_wr_q]  <= trk_dest_q[trk_rd_q];
            res_cid_q[res_wr_q]   <= trk_cid_q[trk_rd_q];
        end
    end

endmodule

// File: tb/tb_resource_branch_mo.sv
// Directed bench for resource_branch_mo; a second instance with sign_extend=0 shares the inputs.
module tb_resource_branch_mo;

    logic clk = 1'b0;
    logic reset, enable, in_valid, write, req_ready, read_valid, write_ack, out_ready;
    logic [7:0]  block_in, handle_in, commit_id_in;
    logic [15:0] arg_a_in, arg_b_in, data_in;
    logic [3:0]  dest_in;

    logic in_ready, read_req, write_req, out_valid, idle, proto_err;
    logic [7:0]  handle_out, block_out, commit_id_out;
    logic [15:0] arg_a_out, arg_b_out;
    logic [31:0] result_out;
    logic [3:0]  dest_out;

    logic z_in_ready, z_read_req, z_write_req, z_out_valid, z_idle, z_proto_err;
    logic [7:0]  z_handle_out, z_block_out, z_commit_id_out;
    logic [15:0] z_arg_a_out, z_arg_b_out;
    logic [31:0] z_result_out;
    logic [3:0]  z_dest_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    resource_branch_mo dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .write(write), .block_in(block_in), .handle_in(handle_in), .arg_a_in(arg_a_in),
        .arg_b_in(arg_b_in), .dest_in(dest_in), .commit_id_in(commit_id_in),
        .read_req(read_req), .write_req(write_req), .req_ready(req_ready),
        .handle_out(handle_out), .arg_a_out(arg_a_out), .arg_b_out(arg_b_out),
        .read_valid(read_valid), .data_in(data_in), .write_ack(write_ack),
        .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
        .block_out(block_out), .dest_out(dest_out), .commit_id_out(commit_id_out),
        .idle(idle), .proto_err(proto_err)
    );

    resource_branch_mo #(.sign_extend(1'b0)) dut_zx (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(z_in_ready),
        .write(write), .block_in(block_in), .handle_in(handle_in), .arg_a_in(arg_a_in),
        .arg_b_in(arg_b_in), .dest_in(dest_in), .commit_id_in(commit_id_in),
        .read_req(z_read_req), .write_req(z_write_req), .req_ready(req_ready),
        .handle_out(z_handle_out), .arg_a_out(z_arg_a_out), .arg_b_out(z_arg_b_out),
        .read_valid(read_valid), .data_in(data_in), .write_ack(write_ack),
        .out_valid(z_out_valid), .out_ready(out_ready), .result_out(z_result_out),
        .block_out(z_block_out), .dest_out(z_dest_out), .commit_id_out(z_commit_id_out),
        .idle(z_idle), .proto_err(z_proto_err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic wr, input logic [7:0] h, input logic [3:0] d,
                        input logic [7:0] cid, input logic [7:0] blk);
        in_valid = 1'b1; write = wr; handle_in = h; dest_in = d; commit_id_in = cid;
        block_in = blk; arg_a_in = {8'hA0, h}; arg_b_in = {8'hB0, h};
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step; step;
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({read_req, write_req, out_valid} !== 3'b000) begin n_bad++; $display("FAIL rst_req_valid: got %b want 000", {read_req, write_req, out_valid}); end
        n_cmp++; if (idle !== 1'b1 || proto_err !== 1'b0) begin n_bad++; $display("FAIL rst_idle_err: got %b%b want 10", idle, proto_err); end
        n_cmp++; if ({result_out, block_out, dest_out, commit_id_out} !== 52'h0) begin n_bad++; $display("FAIL rst_outputs: got %h want 0", {result_out, block_out, dest_out, commit_id_out}); end
    endtask

    task automatic test_single_read;
        req_ready = 1'b1;
        load(1'b0, 8'h05, 4'd3, 8'h42, 8'h07);
        step;
        in_valid = 1'b0;
        n_cmp++; if (read_req !== 1'b1 || write_req !== 1'b0) begin n_bad++; $display("FAIL single_req: got rd=%b wr=%b want rd=1 wr=0", read_req, write_req); end
        n_cmp++; if (handle_out !== 8'h05 || arg_a_out !== 16'hA005 || arg_b_out !== 16'hB005) begin n_bad++; $display("FAIL single_issue_bus: got %h %h %h want 05 a005 b005", handle_out, arg_a_out, arg_b_out); end
        step;
        n_cmp++; if (read_req !== 1'b0 || idle !== 1'b0) begin n_bad++; $display("FAIL single_after_fire: got req=%b idle=%b want 0 0", read_req, idle); end
        step; step;
        read_valid = 1'b1; data_in = 16'h8001;
        step;
        read_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || result_out !== 32'hFFFF8001) begin n_bad++; $display("FAIL single_result_sx: got v=%b %h want 1 ffff8001", out_valid, result_out); end
        n_cmp++; if (z_result_out !== 32'h00008001) begin n_bad++; $display("FAIL single_result_zx: got %h want 00008001", z_result_out); end
        n_cmp++; if (dest_out !== 4'd3 || commit_id_out !== 8'h42 || block_out !== 8'h07) begin n_bad++; $display("FAIL single_meta: got %h %h %h want 3 42 07", dest_out, commit_id_out, block_out); end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || idle !== 1'b1) begin n_bad++; $display("FAIL single_drain: got v=%b idle=%b want 0 1", out_valid, idle); end
    endtask

    task automatic test_four_reads;
        req_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            load(1'b0, 8'(i), 4'(i), 8'(8'h10 + i), 8'(i));
            step;
        end
        in_valid = 1'b0;
        step; step;
        n_cmp++; if (read_req !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL four_held: got req=%b in_ready=%b want 0 0", read_req, in_ready); end
        n_cmp++; if (handle_out !== 8'h05) begin n_bad++; $display("FAIL four_held_handle: got %h want 05", handle_out); end
        for (int i = 1; i <= 4; i++) begin
            read_valid = 1'b1; data_in = 16'(i);
            step;
        end
        read_valid = 1'b0;
        n_cmp++; if (read_req !== 1'b0) begin n_bad++; $display("FAIL four_full_credit: got %b want 0", read_req); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || result_out !== 32'(i) || dest_out !== 4'(i)) begin n_bad++; $display("FAIL four_order_%0d: got v=%b %h d=%h want 1 %h %h", i, out_valid, result_out, dest_out, 32'(i), 4'(i)); end
            step;
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || idle !== 1'b0) begin n_bad++; $display("FAIL four_fifth_flight: got v=%b idle=%b want 0 0", out_valid, idle); end
        read_valid = 1'b1; data_in = 16'h0005;
        step;
        read_valid = 1'b0;
        n_cmp++; if (result_out !== 32'h5 || commit_id_out !== 8'h15) begin n_bad++; $display("FAIL four_fifth_result: got %h %h want 5 15", result_out, commit_id_out); end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        n_cmp++; if (idle !== 1'b1 || proto_err !== 1'b0) begin n_bad++; $display("FAIL four_idle: got idle=%b err=%b want 1 0", idle, proto_err); end
    endtask

    task automatic test_interleaved;
        req_ready = 1'b1;
        load(1'b1, 8'h10, 4'd0, 8'h01, 8'h01);
        step;
        n_cmp++; if (write_req !== 1'b1 || read_req !== 1'b0) begin n_bad++; $display("FAIL inter_wr_req: got wr=%b rd=%b want 1 0", write_req, read_req); end
        load(1'b0, 8'h11, 4'd9, 8'h99, 8'h02);
        step;
        load(1'b1, 8'h12, 4'd0, 8'h03, 8'h03);
        step;
        in_valid = 1'b0;
        step;
        write_ack = 1'b1;
        step;
        write_ack = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL inter_write_silent: got %b want 0", out_valid); end
        read_valid = 1'b1; data_in = 16'h1234;
        step;
        read_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || result_out !== 32'h1234 || dest_out !== 4'd9 || commit_id_out !== 8'h99) begin n_bad++; $display("FAIL inter_read: got v=%b %h %h %h want 1 1234 9 99", out_valid, result_out, dest_out, commit_id_out); end
        write_ack = 1'b1; out_ready = 1'b1;
        step;
        write_ack = 1'b0; out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || proto_err !== 1'b0 || idle !== 1'b1) begin n_bad++; $display("FAIL inter_end: got v=%b err=%b idle=%b want 0 0 1", out_valid, proto_err, idle); end
    endtask

    task automatic test_enable_freeze;
        req_ready = 1'b1;
        load(1'b0, 8'h20, 4'd5, 8'h55, 8'h09);
        step;
        in_valid = 1'b0;
        step;
        read_valid = 1'b1; data_in = 16'h7ABC;
        step;
        read_valid = 1'b0;
        enable = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            read_valid = (k == 1); data_in = 16'h1111;
            #1;
            n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL freeze_%0d: got v=%b in_ready=%b want 0 0", k, out_valid, in_ready); end
            step;
        end
        read_valid = 1'b0;
        n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL freeze_resp_ignored: got err=%b want 0", proto_err); end
        enable = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || result_out !== 32'h00007ABC || dest_out !== 4'd5) begin n_bad++; $display("FAIL freeze_resume: got v=%b %h %h want 1 7abc 5", out_valid, result_out, dest_out); end
        step;
        out_ready = 1'b0;
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL freeze_idle: got %b want 1", idle); end
    endtask

    task automatic test_mismatch;
        req_ready = 1'b1;
        load(1'b0, 8'h30, 4'd6, 8'h66, 8'h04);
        step;
        in_valid = 1'b0;
        step;
        write_ack = 1'b1;
        step;
        write_ack = 1'b0;
        n_cmp++; if (proto_err !== 1'b1 || out_valid !== 1'b0 || idle !== 1'b1) begin n_bad++; $display("FAIL mismatch: got err=%b v=%b idle=%b want 1 0 1", proto_err, out_valid, idle); end
        step; step;
        n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL mismatch_sticky: got %b want 1", proto_err); end
    endtask

    task automatic test_reset_midflight;
        req_ready = 1'b1;
        load(1'b0, 8'h40, 4'd1, 8'h01, 8'h01);
        step;
        req_ready = 1'b0;
        load(1'b1, 8'h41, 4'd2, 8'h02, 8'h02);
        step;
        in_valid = 1'b0;
        reset = 1'b1;
        step;
        reset = 1'b0;
        n_cmp++; if (idle !== 1'b1 || proto_err !== 1'b0 || write_req !== 1'b0) begin n_bad++; $display("FAIL midrst_clear: got idle=%b err=%b wr=%b want 1 0 0", idle, proto_err, write_req); end
        read_valid = 1'b1; data_in = 16'h2222;
        step;
        read_valid = 1'b0;
        n_cmp++; if (proto_err !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_late_resp: got err=%b v=%b want 1 0", proto_err, out_valid); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; write = 1'b0; req_ready = 1'b0;
        read_valid = 1'b0; write_ack = 1'b0; out_ready = 1'b0;
        block_in = '0; handle_in = '0; commit_id_in = '0; arg_a_in = '0; arg_b_in = '0;
        data_in = '0; dest_in = '0;
        test_reset;
        test_single_read;
        test_four_reads;
        test_interleaved;
        test_enable_freeze;
        test_mismatch;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
